pwm_seq_ctrl: RTL

PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

---
 rtl/pwm_seq_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_seq_ctrl
//
// Breathing-LED sequencer. A 10-slot PWM frame is built from a slot tick that
// fires every TICK_MAX+1 clocks. After a start request the duty level ramps
// 0 -> 10 in steps of STEP_FRAMES frames, holds at full brightness for
// HOLD_FRAMES frames, then ramps back down to 0. With loop set the sequence
// starts over from the bottom of the fade-out; otherwise the block goes idle.
// A stop request during ramp-up or hold jumps straight into the fade-out from
// the current level, so the LEDs never snap off.
//
// Ports
//   clk       single clock
//   rst       synchronous, active-high reset
//   start     one-cycle request to begin a sequence (only honoured in IDLE)
//   stop      one-cycle request for a graceful fade-out
//   loop      restart the sequence after fade-out when 1
//   led_mask  LEDs to drive, captured when a start is accepted
//   led       LED drive, active-low (0 = on)
//   duty      current (unmapped) duty level, 0..10
//   busy      1 whenever the sequencer is not idle
//
// Build option
//   PWM_GAMMA_EN  when defined, the level used for PWM compare is gamma-mapped
//                 (0,0,1,1,2,3,4,5,6,8,10); the duty port stays unmapped.
// ---------------------------------------------------------------------------
module pwm_seq_ctrl #(
   parameter int TICK_MAX    = 26999,
   parameter int STEP_FRAMES = 10,
   parameter int HOLD_FRAMES = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   input  logic [7:0] led_mask,
   output logic [7:0] led,
   output logic [3:0] duty,
   output logic       busy
);

   localparam int TICK_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam int FRAME_MAX = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
   localparam int FCNT_W    = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);
   localparam logic [FCNT_W-1:0] STEP_LAST = FCNT_W'(STEP_FRAMES - 1);
   localparam logic [FCNT_W-1:0] HOLD_LAST = FCNT_W'(HOLD_FRAMES - 1);
   localparam logic [3:0]        DUTY_FULL = 4'd10;
   localparam logic [3:0]        SLOT_LAST = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      RAMP_UP,
      HOLD,
      RAMP_DN
   } stateT;

   stateT             state;
   logic [TICK_W-1:0] tickCnt;
   logic [3:0]        slot;
   logic [FCNT_W-1:0] fcnt;
   logic [7:0]        mask;
   logic              tick;
   logic              frameEnd;
   logic              stepDone;
   logic [3:0]        dutyUp;
   logic [3:0]        dutyDn;
   logic [3:0]        effDuty;

   assign tick     = (tickCnt == TICK_LAST);
   assign frameEnd = tick && (slot == SLOT_LAST);
   assign stepDone = frameEnd && (fcnt == STEP_LAST);
   assign busy     = (state != IDLE);

   // Saturating neighbours of the current level; the FSM only ever loads one
   // of these, so duty can never wrap past 0 or 10.
   assign dutyUp = (duty >= DUTY_FULL) ? DUTY_FULL : duty + 4'd1;
   assign dutyDn = (duty == 4'd0) ? 4'd0 : duty - 4'd1;

`ifdef PWM_GAMMA_EN
   // Perceptual correction: low levels are compressed so the fade looks
   // linear to the eye. Anything above 10 cannot occur but maps to full.
   always_comb begin
      effDuty = 4'd0;
      case (duty)
         4'd0, 4'd1: effDuty = 4'd0;
         4'd2, 4'd3: effDuty = 4'd1;
         4'd4:       effDuty = 4'd2;
         4'd5:       effDuty = 4'd3;
         4'd6:       effDuty = 4'd4;
         4'd7:       effDuty = 4'd5;
         4'd8:       effDuty = 4'd6;
         4'd9:       effDuty = 4'd8;
         default:    effDuty = 4'd10;
      endcase
   end
`else
   assign effDuty = duty;
`endif

   // Slot timebase. The counters are held at zero while idle, which also
   // gives every accepted start a clean frame boundary. Once running they
   // free-run across phase changes so a stop or loop restart never produces
   // a shortened frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         tickCnt <= '0;
         slot    <= 4'd0;
      end else if (state == IDLE) begin
         tickCnt <= '0;
         slot    <= 4'd0;
      end else if (tick) begin
         tickCnt <= '0;
         slot    <= (slot == SLOT_LAST) ? 4'd0 : slot + 4'd1;
      end else begin
         tickCnt <= tickCnt + 1'b1;
      end
   end

   // Sequencer. Level changes only happen on a frame boundary so a frame is
   // always drawn with a single duty value. Stop beats start in the same
   // cycle, and a stop while already fading (or idle) has nothing to do.
   // The loop input is only looked at when the fade-out reaches zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         duty  <= 4'd0;
         fcnt  <= '0;
         mask  <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  mask  <= led_mask;
                  duty  <= 4'd0;
                  fcnt  <= '0;
                  state <= RAMP_UP;
               end
            end
            RAMP_UP: begin
               if (stop) begin
                  fcnt  <= '0;
                  state <= RAMP_DN;
               end else if (stepDone) begin
                  fcnt <= '0;
                  duty <= dutyUp;
                  if (dutyUp == DUTY_FULL) begin
                     state <= HOLD;
                  end
               end else if (frameEnd) begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            HOLD: begin
               if (stop) begin
                  fcnt  <= '0;
                  state <= RAMP_DN;
               end else if (frameEnd) begin
                  if (fcnt == HOLD_LAST) begin
                     fcnt  <= '0;
                     state <= RAMP_DN;
                  end else begin
                     fcnt <= fcnt + 1'b1;
                  end
               end
            end
            RAMP_DN: begin
               if (stepDone) begin
                  fcnt <= '0;
                  duty <= dutyDn;
                  if (dutyDn == 4'd0) begin
                     state <= loop ? RAMP_UP : IDLE;
                  end
               end else if (frameEnd) begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // LED drive, one clock behind slot/duty. A masked LED is lit for the
   // first effDuty slots of every frame; idle forces everything dark.
   always_ff @(posedge clk) begin
      if (rst) begin
         led <= 8'hFF;
      end else if (state == IDLE) begin
         led <= 8'hFF;
      end else begin
         led <= ~(mask & {8{slot < effDuty}});
      end
   end

endmodule
